// File: rtl/unit_arbiter.sv
// unit_arbiter: round-robin responder that serves thread unit requests one at a time
// on a shared combinational ALU or a handshaked memory port.
package unit_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef logic [1:0] unit_sel_t;
    localparam unit_sel_t UNIT_SEL_ALU = 2'd0;
    localparam unit_sel_t UNIT_SEL_MEM = 2'd1;
endpackage

module unit_arbiter
    import unit_arbiter_pkg::*;
#(
    parameter int NUM_THREADS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_THREADS-1:0]              req_valid,
    input  unit_sel_t [NUM_THREADS-1:0]         req_sel,
    input  word_t [NUM_THREADS-1:0]             req_ctrl,
    input  word_t [NUM_THREADS-1:0][1:0]        req_in,
    output logic [NUM_THREADS-1:0]              rsp_valid,
    output word_t                               rsp_data,
    output logic                                rsp_err,
    output word_t                               alu_ctrl,
    output word_t [1:0]                         alu_in,
    input  word_t                               alu_out,
    output logic                                mem_req,
    output word_t                               mem_ctrl,
    output word_t                               mem_addr,
    output word_t                               mem_wdata,
    input  logic                                mem_ack,
    input  word_t                               mem_rdata,
    output logic                                busy
);
    localparam int GW = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1;

    typedef enum logic [1:0] {IDLE, ALU, MEM, DONE} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick;
    word_t         ctrl_q, ctrl_d, op0_q, op0_d, op1_q, op1_d, data_q, data_d;
    logic          err_q, err_d, found;
    int            idx;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ctrl_d  = ctrl_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        data_d  = data_q;
        err_d   = err_q;
        found   = 1'b0;
        pick    = '0;
        idx     = 0;
        // Search starts just after the last winner so every thread gets a turn.
        for (int i = 1; i <= NUM_THREADS; i++) begin
            idx = (int'(last_q) + i) % NUM_THREADS;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                last_d  = pick;
                ctrl_d  = req_ctrl[pick];
                op0_d   = req_in[pick][0];
                op1_d   = req_in[pick][1];
                err_d   = !(req_sel[pick] inside {UNIT_SEL_ALU, UNIT_SEL_MEM});
                data_d  = err_d ? '0 : data_q;
                state_d = req_sel[pick] == UNIT_SEL_ALU ? ALU :
                          req_sel[pick] == UNIT_SEL_MEM ? MEM : DONE;
            end
            ALU: begin
                data_d  = alu_out;
                state_d = DONE;
            end
            MEM: if (mem_ack) begin
                data_d  = mem_rdata;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_THREADS - 1);
            ctrl_q  <= '0;
            op0_q   <= '0;
            op1_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ctrl_q  <= ctrl_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign rsp_valid = state_q == DONE ? NUM_THREADS'(1) << grant_q : '0;
    assign rsp_data  = data_q;
    assign rsp_err   = state_q == DONE && err_q;
    assign alu_ctrl  = state_q == ALU ? ctrl_q : '0;
    assign alu_in[0] = state_q == ALU ? op0_q : '0;
    assign alu_in[1] = state_q == ALU ? op1_q : '0;
    assign mem_req   = state_q == MEM;
    assign mem_ctrl  = state_q == MEM ? ctrl_q : '0;
    assign mem_addr  = state_q == MEM ? op0_q : '0;
    assign mem_wdata = state_q == MEM ? op1_q : '0;
endmodule

// File: tb/tb_unit_arbiter.sv
// tb_unit_arbiter: directed scenarios for unit_arbiter with an a+b ALU model
// and a hand-driven memory acknowledge.
module tb_unit_arbiter;
    import unit_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    unit_sel_t [1:0]  req_sel = '0;
    word_t [1:0]      req_ctrl = '0;
    word_t [1:0][1:0] req_in = '0;
    logic [1:0]       rsp_valid;
    word_t            rsp_data;
    logic             rsp_err;
    word_t            alu_ctrl;
    word_t [1:0]      alu_in;
    word_t            alu_out;
    logic             mem_req;
    word_t            mem_ctrl, mem_addr, mem_wdata;
    logic             mem_ack = 1'b0;
    word_t            mem_rdata = '0;
    logic             busy;
    int               checks = 0;
    int               errors = 0;

    unit_arbiter #(.NUM_THREADS(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
        .req_ctrl(req_ctrl), .req_in(req_in), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_ctrl(alu_ctrl),
        .alu_in(alu_in), .alu_out(alu_out), .mem_req(mem_req),
        .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    assign alu_out = alu_in[0] + alu_in[1];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (mem_req !== 1'b0 || alu_ctrl !== 32'h0) begin errors++; $display("FAIL reset_units: got mem_req=%b alu_ctrl=%h want 0/0", mem_req, alu_ctrl); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_single();
        req_valid = 2'b01; req_sel[0] = UNIT_SEL_ALU; req_ctrl[0] = 32'h3;
        req_in[0][0] = 32'd5; req_in[0][1] = 32'd7;
        tick();
        checks++; if (alu_in[0] !== 32'd5 || alu_in[1] !== 32'd7) begin errors++; $display("FAIL alu_single_in: got %0d,%0d want 5,7", alu_in[0], alu_in[1]); end
        checks++; if (alu_ctrl !== 32'h3 || rsp_valid !== 2'b00) begin errors++; $display("FAIL alu_single_c1: got ctrl=%h rsp=%b want 3/00", alu_ctrl, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd12 || rsp_err !== 1'b0) begin errors++; $display("FAIL alu_single_rsp: got v=%b d=%0d e=%b want 01/12/0", rsp_valid, rsp_data, rsp_err); end
        checks++; if (alu_ctrl !== 32'h0 || alu_in[0] !== 32'h0) begin errors++; $display("FAIL alu_single_idle_drive: got ctrl=%h in0=%h want 0/0", alu_ctrl, alu_in[0]); end
        req_valid = 2'b00;
        tick();
        checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL alu_single_c3: got busy=%b rsp=%b want 0/00", busy, rsp_valid); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        req_sel = {UNIT_SEL_ALU, UNIT_SEL_ALU};
        req_in[0][0] = 32'd1;  req_in[0][1] = 32'd2;
        req_in[1][0] = 32'd10; req_in[1][1] = 32'd20;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (alu_in[0] !== (k % 2 == 0 ? 32'd1 : 32'd10)) begin errors++; $display("FAIL rr_grant%0d: got in0=%0d want %0d", k, alu_in[0], k % 2 == 0 ? 1 : 10); end
            tick();
            checks++; if (rsp_valid !== (k % 2 == 0 ? 2'b01 : 2'b10) || rsp_data !== (k % 2 == 0 ? 32'd3 : 32'd30)) begin errors++; $display("FAIL rr_rsp%0d: got v=%b d=%0d want %b/%0d", k, rsp_valid, rsp_data, k % 2 == 0 ? 2'b01 : 2'b10, k % 2 == 0 ? 3 : 30); end
            if (k == 3) req_valid = 2'b00;
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_mem_wait();
        req_valid = 2'b10; req_sel[1] = UNIT_SEL_MEM; req_ctrl[1] = 32'h7;
        req_in[1][0] = 32'h100; req_in[1][1] = 32'h55;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) begin req_in[1][0] = 32'hBAD; req_ctrl[1] = 32'hBAD; end
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h55 || mem_ctrl !== 32'h7) begin errors++; $display("FAIL mem_wait_c%0d: got req=%b addr=%h wd=%h ctrl=%h want 1/100/55/7", c, mem_req, mem_addr, mem_wdata, mem_ctrl); end
            checks++; if (rsp_valid !== 2'b00 || alu_ctrl !== 32'h0) begin errors++; $display("FAIL mem_wait_quiet%0d: got rsp=%b alu_ctrl=%h want 00/0", c, rsp_valid, alu_ctrl); end
            if (c == 4) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
        end
        tick();
        mem_ack = 1'b0;
        checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hDEADBEEF || mem_req !== 1'b0) begin errors++; $display("FAIL mem_wait_rsp: got v=%b d=%h req=%b want 10/deadbeef/0", rsp_valid, rsp_data, mem_req); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_unsupported();
        req_valid = 2'b01; req_sel[0] = 2'd2; req_ctrl[0] = 32'h9;
        req_in[0][0] = 32'h11; req_in[0][1] = 32'h22;
        tick();
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL unsup_rsp: got v=%b e=%b d=%h want 01/1/0", rsp_valid, rsp_err, rsp_data); end
        checks++; if (mem_req !== 1'b0 || alu_ctrl !== 32'h0 || alu_in[0] !== 32'h0) begin errors++; $display("FAIL unsup_units: got req=%b ctrl=%h in0=%h want 0/0/0", mem_req, alu_ctrl, alu_in[0]); end
        req_valid = 2'b00;
        tick();
        checks++; if (rsp_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL unsup_after: got e=%b busy=%b want 0/0", rsp_err, busy); end
    endtask

    task automatic test_reset_mid_mem();
        req_valid = 2'b01; req_sel[0] = UNIT_SEL_MEM; req_in[0][0] = 32'h40;
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmm_req_before: got %b want 1", mem_req); end
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL rmm_async: got req=%b busy=%b rsp=%b want 0/0/00", mem_req, busy, rsp_valid); end
        mem_ack = 1'b1;
        rst_n = 1'b1;
        req_sel = {UNIT_SEL_ALU, UNIT_SEL_ALU};
        req_in[0][0] = 32'd3;   req_in[0][1] = 32'd4;
        req_in[1][0] = 32'd100; req_in[1][1] = 32'd100;
        req_valid = 2'b11;
        tick();
        mem_ack = 1'b0;
        checks++; if (alu_in[0] !== 32'd3 || mem_req !== 1'b0) begin errors++; $display("FAIL rmm_first_grant: got in0=%0d req=%b want 3/0", alu_in[0], mem_req); end
        req_valid = 2'b00;
        tick();
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd7) begin errors++; $display("FAIL rmm_rsp: got v=%b d=%0d want 01/7", rsp_valid, rsp_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        req_valid = 2'b01; req_sel[0] = UNIT_SEL_ALU;
        req_in[0][0] = 32'd4; req_in[0][1] = 32'd5;
        tick();
        tick();
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd9) begin errors++; $display("FAIL b2b_first: got v=%b d=%0d want 01/9", rsp_valid, rsp_data); end
        req_in[0][0] = 32'd1; req_in[0][1] = 32'd1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
        tick();
        checks++; if (alu_in[0] !== 32'd1 || alu_in[1] !== 32'd1) begin errors++; $display("FAIL b2b_regrant: got %0d,%0d want 1,1", alu_in[0], alu_in[1]); end
        req_valid = 2'b00;
        tick();
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin errors++; $display("FAIL b2b_second: got v=%b d=%0d want 01/2", rsp_valid, rsp_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_round_robin();
        test_mem_wait();
        test_unsupported();
        test_reset_mid_mem();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unit_arbiter.md
# unit_arbiter

Responder side of the thread unit-request interface: accepts unit requests (unit select, control word, two operands) from `NUM_THREADS` threads and serves them one at a time. ALU requests are driven to a shared combinational ALU; memory requests go to a shared memory port with a request/acknowledge handshake. Grants are round-robin. Each result is returned with a one-cycle response strobe to the requesting thread. The block sits between the thread array and the shared execution units.

## Interface
Parameters:
- `NUM_THREADS`, 2: number of requesting threads, ≥1.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_THREADS`  per-thread request pending; held until that thread's `rsp_valid`.
- `req_sel`  in  `NUM_THREADS` x `unit_sel_t`  per-thread unit select (`UNIT_SEL_ALU`, `UNIT_SEL_MEM`).
- `req_ctrl`  in  `NUM_THREADS` x `word_t`  per-thread unit control word.
- `req_in`  in  `NUM_THREADS` x 2 x `word_t`  per-thread operands: `[0]` rs1/address, `[1]` rs2/immediate/write data.
- `rsp_valid`  out  `NUM_THREADS`  one-hot, one-cycle response strobe.
- `rsp_data`  out  `word_t`  result, shared by all threads; valid only while some `rsp_valid` bit is set.
- `rsp_err`  out  1  asserted together with `rsp_valid` when `req_sel` was unsupported.
- `alu_ctrl`, `alu_in[0]`, `alu_in[1]`  out  `word_t`  ALU drive.
- `alu_out`  in  `word_t`  ALU result, combinational from `alu_*`.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_ctrl`, `mem_addr`, `mem_wdata`  out  `word_t`  memory command, address, write data.
- `mem_ack`  in  1  memory done; sampled only while `mem_req`=1.
- `mem_rdata`  in  `word_t`  read data, valid in the `mem_ack` cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ALU, MEM, DONE.
- IDLE:
  - If any `req_valid` bit is set, grant the first set bit searching from `last_grant+1`, wrapping modulo `NUM_THREADS`.
  - Latch `req_sel`, `req_ctrl`, `req_in[0]`, `req_in[1]` and the grant index; update `last_grant`.
  - Next state: ALU for `UNIT_SEL_ALU`, MEM for `UNIT_SEL_MEM`.
  - Any other select: next state DONE, with `rsp_data`=0 and `rsp_err`=1.
- ALU:
  - Drive `alu_ctrl`/`alu_in` from the latched request.
  - At the clock edge, register `alu_out` into `rsp_data` and go to DONE.
- MEM:
  - Drive `mem_req`=1 and `mem_ctrl`/`mem_addr`/`mem_wdata` from the latched request, stable until ack.
  - On `mem_ack`=1, register `mem_rdata` into `rsp_data` and go to DONE.
  - The block has no timeout.
- DONE: `rsp_valid[grant]`=1 for exactly this cycle; next state IDLE.
- Requests are not accepted in ALU, MEM or DONE.
- `req_valid` seen in IDLE after DONE counts as a new request, even if the same thread never dropped it.
- `alu_*` outputs are 0 outside ALU; `mem_*` outputs are 0 outside MEM.
- `last_grant` resets to `NUM_THREADS-1`, so thread 0 wins the first arbitration.

## Timing
- Reset values: state IDLE, `last_grant`=`NUM_THREADS-1`. All outputs 0: `rsp_valid`, `rsp_data`, `rsp_err`, `alu_*`, `mem_*`, `busy`.
- Reset assertion forces all outputs to 0 immediately, asynchronously.
  - This includes dropping `mem_req` mid-transaction; the memory must tolerate an abandoned request.
  - A pending `mem_ack` after reset is ignored.
- ALU latency: grant in cycle N (IDLE), ALU in N+1, `rsp_valid` in N+2.
- Memory latency: grant in N, `mem_req` high from N+1. If `mem_ack` arrives in cycle M, `rsp_valid` is in M+1.
- Unsupported select: grant in N, `rsp_valid` and `rsp_err` in N+1.
- Throughput: at most one grant per 3 cycles (ALU path); next arbitration in N+3.
- Simultaneous requests: round-robin only; no thread waits more than `NUM_THREADS-1` grants.
- A requester changing `req_*` after its grant has no effect until its response.
- `req_valid` deassertion before the response is a protocol violation; the result is still delivered.

## Test plan
- ALU single: thread 0 requests ALU, operands 5 and 7; ALU model returns a+b. Required: `alu_in`=(5,7) in cycle 1, `rsp_valid`=01 and `rsp_data`=12 in cycle 2, `busy` low in cycle 3.
- Round-robin: both threads hold ALU requests continuously. Required: grants 0,1,0,1 at cycles 0,3,6,9; `rsp_valid`=01,10,01,10 at cycles 2,5,8,11.
- Memory wait: thread 1 requests MEM at address 0x100; `mem_ack` arrives 3 cycles after `mem_req` rises, with `mem_rdata`=0xDEADBEEF. Required: `mem_req` high 4 cycles with `mem_addr`=0x100 stable, then `rsp_valid`=10 and `rsp_data`=0xDEADBEEF the next cycle.
- Unsupported select: thread 0 sends a non-ALU, non-MEM select. Required: `rsp_valid`=01, `rsp_err`=1, `rsp_data`=0 one cycle after grant; no `alu_*`/`mem_req` activity.
- Reset mid-MEM: assert `rst_n`=0 while `mem_req`=1, between clock edges. Required: `mem_req`, `busy`, `rsp_valid` all 0 before the next edge. After release, with both threads requesting, thread 0 is granted first.
- Held request: thread 0 keeps `req_valid`=1 through DONE, with new operands (1,1). Required: re-granted in the cycle after DONE, second `rsp_data`=2.
